// File: rtl/systolic_feeder.sv
// Edge driver for a column-chained PE array: loads stationary weights, strobes the
// weight latch, then streams diagonally skewed activation vectors. Optional: FEEDER_VEC_CNT_EN.
module systolic_feeder #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned DW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [DW-1:0]        w_data,
    input  logic                 v_valid,
    output logic                 v_ready,
    input  logic [ROWS*DW-1:0]   v_data,
    input  logic                 v_last,
    output logic [DW-1:0]        pe_b,
    output logic                 pe_b_valid,
    output logic                 pe_switch,
    output logic [ROWS*DW-1:0]   pe_a,
    output logic [ROWS-1:0]      pe_a_valid,
    output logic                 busy,
    output logic                 done
`ifdef FEEDER_VEC_CNT_EN
    ,
    output logic [15:0]          vec_cnt
`endif
);

    localparam int unsigned CW         = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned W_LAST     = ROWS - 1;
    localparam int unsigned FLUSH_LAST = (ROWS > 1) ? ROWS - 2 : 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LATCH  = 3'd2,
        STREAM = 3'd3,
        FLUSH  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   w_cnt;
    logic [CW-1:0]   w_cnt_d;
    logic [CW-1:0]   f_cnt;
    logic [CW-1:0]   f_cnt_d;
    logic [DW-1:0]   pe_b_d;
    logic            pe_b_valid_d;
    logic            w_fire;
    logic            v_fire;

    assign w_fire = w_valid & w_ready;
    assign v_fire = v_valid & v_ready;

    // Next-state and weight-path decisions
    always_comb begin
        next_state   = state;
        w_cnt_d      = w_cnt;
        f_cnt_d      = f_cnt;
        pe_b_d       = pe_b;
        pe_b_valid_d = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD_W;
                    w_cnt_d    = '0;
                end
            end
            LOAD_W: begin
                if (w_fire) begin
                    pe_b_d       = w_data;
                    pe_b_valid_d = 1'b1;
                    if (w_cnt == CW'(W_LAST)) begin
                        next_state = LATCH;
                        w_cnt_d    = '0;
                    end else begin
                        w_cnt_d = CW'(w_cnt + 1'b1);
                    end
                end
            end
            LATCH: begin
                pe_b_d     = '0;
                next_state = STREAM;
            end
            STREAM: begin
                if (v_fire && v_last) begin
                    f_cnt_d    = '0;
                    next_state = (ROWS > 1) ? FLUSH : DONE;
                end
            end
            FLUSH: begin
                if (f_cnt == CW'(FLUSH_LAST)) begin
                    next_state = DONE;
                end else begin
                    f_cnt_d = CW'(f_cnt + 1'b1);
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Ready flags follow the upcoming state so they match the state they qualify;
    // status strobes are registered copies of the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            w_cnt      <= '0;
            f_cnt      <= '0;
            pe_b       <= '0;
            pe_b_valid <= 1'b0;
            pe_switch  <= 1'b0;
            w_ready    <= 1'b0;
            v_ready    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= next_state;
            w_cnt      <= w_cnt_d;
            f_cnt      <= f_cnt_d;
            pe_b       <= pe_b_d;
            pe_b_valid <= pe_b_valid_d;
            pe_switch  <= (state == LATCH);
            w_ready    <= (next_state == LOAD_W);
            v_ready    <= (next_state == STREAM);
            busy       <= (state != IDLE);
            done       <= (state == DONE);
        end
    end

    // Per-row skew line: row r holds r+1 registers, the last one drives the PE input
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [r:0][DW-1:0] sd;
        logic [r:0]         sv;
        logic [DW-1:0]      inj;

        assign inj = v_fire ? v_data[r*DW +: DW] : '0;

        if (r == 0) begin : g_d0
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sd <= '0;
                    sv <= '0;
                end else begin
                    sd <= inj;
                    sv <= v_fire;
                end
            end
        end else begin : g_dn
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sd <= '0;
                    sv <= '0;
                end else begin
                    sd <= {sd[r-1:0], inj};
                    sv <= {sv[r-1:0], v_fire};
                end
            end
        end

        assign pe_a[r*DW +: DW] = sd[r];
        assign pe_a_valid[r]    = sv[r];
    end

`ifdef FEEDER_VEC_CNT_EN
    // Accepted-vector count for the current or most recent job, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            vec_cnt <= '0;
        end else if (v_fire && (vec_cnt != 16'hFFFF)) begin
            vec_cnt <= 16'(vec_cnt + 1'b1);
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: random jobs checked every cycle against a
// timeline model built from accepted handshakes (cycle numbers plus fixed latencies).
module tb_systolic_feeder;

    localparam int unsigned ROWS = 4;
    localparam int unsigned DW   = 32;
    localparam int          INF  = 32'h3fffffff;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                w_valid;
    logic                w_ready;
    logic [DW-1:0]       w_data;
    logic                v_valid;
    logic                v_ready;
    logic [ROWS*DW-1:0]  v_data;
    logic                v_last;
    logic [DW-1:0]       pe_b;
    logic                pe_b_valid;
    logic                pe_switch;
    logic [ROWS*DW-1:0]  pe_a;
    logic [ROWS-1:0]     pe_a_valid;
    logic                busy;
    logic                done;
`ifdef FEEDER_VEC_CNT_EN
    logic [15:0]         vec_cnt;
    int                  exp_vc;
`endif

    systolic_feeder #(.ROWS(ROWS), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .v_valid    (v_valid),
        .v_ready    (v_ready),
        .v_data     (v_data),
        .v_last     (v_last),
        .pe_b       (pe_b),
        .pe_b_valid (pe_b_valid),
        .pe_switch  (pe_switch),
        .pe_a       (pe_a),
        .pe_a_valid (pe_a_valid),
        .busy       (busy),
        .done       (done)
`ifdef FEEDER_VEC_CNT_EN
        ,
        .vec_cnt    (vec_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Timeline model: events keyed by the cycle in which they become visible / happen
    logic [DW-1:0]      b_evt [int];
    logic [ROWS*DW-1:0] v_evt [int];
    int wr_lo, wr_hi, vr_lo, vr_hi, busy_lo, busy_hi, sw_cyc, done_cyc, vc_clr;
    logic [DW-1:0] cur_b;
    logic [DW-1:0] wtab [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

    function automatic bit inwin(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    task automatic clear_model();
        b_evt.delete();
        v_evt.delete();
        wr_lo = INF; wr_hi = INF; vr_lo = INF; vr_hi = INF;
        busy_lo = INF; busy_hi = INF;
        sw_cyc = -1; done_cyc = -1; vc_clr = -1;
        cur_b = '0;
`ifdef FEEDER_VEC_CNT_EN
        exp_vc = 0;
`endif
    endtask

    task automatic drive_quiet();
        start = 1'b0; w_valid = 1'b0; v_valid = 1'b0; v_last = 1'b0;
        w_data = '0; v_data = '0;
    endtask

    // Advance one clock and compare every output against the timeline model
    task automatic step();
        logic [ROWS*DW-1:0] vv;
        logic [DW-1:0]      ea;
        logic               ev;
        logic               eb;
        @(posedge clk);
        cyc++;
        #1;
        if (b_evt.exists(cyc)) cur_b = b_evt[cyc];
        if (cyc == sw_cyc) cur_b = '0;
        eb = (b_evt.exists(cyc) != 0);
        checks++;
        if (pe_b !== cur_b) begin errors++; $display("FAIL pe_b cyc=%0d got=%h exp=%h", cyc, pe_b, cur_b); end
        checks++;
        if (pe_b_valid !== eb) begin errors++; $display("FAIL pe_b_valid cyc=%0d got=%b exp=%b", cyc, pe_b_valid, eb); end
        checks++;
        if (pe_switch !== (cyc == sw_cyc)) begin errors++; $display("FAIL pe_switch cyc=%0d got=%b exp=%b", cyc, pe_switch, cyc == sw_cyc); end
        checks++;
        if (done !== (cyc == done_cyc)) begin errors++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, cyc == done_cyc); end
        checks++;
        if (busy !== inwin(cyc, busy_lo, busy_hi)) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, inwin(cyc, busy_lo, busy_hi)); end
        checks++;
        if (w_ready !== inwin(cyc, wr_lo, wr_hi)) begin errors++; $display("FAIL w_ready cyc=%0d got=%b exp=%b", cyc, w_ready, inwin(cyc, wr_lo, wr_hi)); end
        checks++;
        if (v_ready !== inwin(cyc, vr_lo, vr_hi)) begin errors++; $display("FAIL v_ready cyc=%0d got=%b exp=%b", cyc, v_ready, inwin(cyc, vr_lo, vr_hi)); end
        for (int r = 0; r < ROWS; r++) begin
            if (v_evt.exists(cyc - 1 - r)) begin
                vv = v_evt[cyc - 1 - r];
                ea = vv[r*DW +: DW];
                ev = 1'b1;
            end else begin
                ea = '0;
                ev = 1'b0;
            end
            checks++;
            if (pe_a_valid[r] !== ev) begin errors++; $display("FAIL pe_a_valid[%0d] cyc=%0d got=%b exp=%b", r, cyc, pe_a_valid[r], ev); end
            checks++;
            if (pe_a[r*DW +: DW] !== ea) begin errors++; $display("FAIL pe_a[%0d] cyc=%0d got=%h exp=%h", r, cyc, pe_a[r*DW +: DW], ea); end
        end
`ifdef FEEDER_VEC_CNT_EN
        if (cyc == vc_clr) exp_vc = 0;
        if (v_evt.exists(cyc - 1)) exp_vc++;
        checks++;
        if (vec_cnt !== 16'(exp_vc)) begin errors++; $display("FAIL vec_cnt cyc=%0d got=%0d exp=%0d", cyc, vec_cnt, exp_vc); end
`endif
    endtask

    task automatic idle(input int n);
        drive_quiet();
        for (int i = 0; i < n; i++) begin
            step();
            w_valid = 1'(($urandom_range(0, 1)));
            v_valid = 1'(($urandom_range(0, 1)));
            w_data  = $urandom;
        end
        drive_quiet();
    endtask

    // One job: wmode 0=continuous,1=toggle,2=random; vmode 0=no gap,1=2-cycle gap after #1,2=random gaps
    task automatic run_job(input int nvec, input int wmode, input int vmode, input bit fixed, input int stop_at);
        int  nw;
        int  nv;
        int  gap;
        int  guard;
        bit  inw;
        bit  inv;
        bit  stop;
        nw = 0; nv = 0; gap = 0; guard = 0; stop = 1'b0;
        drive_quiet();
        start    = 1'b1;
        wr_lo    = cyc + 1; wr_hi = INF;
        busy_lo  = cyc + 2; busy_hi = INF;
        vr_lo    = INF;     vr_hi = INF;
        vc_clr   = cyc + 1;
        done_cyc = INF;
        while (1) begin
            step();
            guard++;
            if (guard > 400) begin
                errors++; checks++;
                $display("FAIL job_timeout cyc=%0d got=no_done exp=done", cyc);
                return;
            end
            if (stop || cyc >= done_cyc) break;
            start = 1'(($urandom_range(0, 1)));
            inw = inwin(cyc, wr_lo, wr_hi);
            case (wmode)
                0:       w_valid = inw ? 1'b1 : 1'(($urandom_range(0, 1)));
                1:       w_valid = inw ? ((cyc - wr_lo) % 2 == 0) : 1'(($urandom_range(0, 1)));
                default: w_valid = 1'(($urandom_range(0, 1)));
            endcase
            w_data = fixed ? wtab[nw % 4] : $urandom;
            if (inw && w_valid) begin
                b_evt[cyc + 1] = w_data;
                nw++;
                if (nw == ROWS) begin
                    wr_hi  = cyc;
                    sw_cyc = cyc + 2;
                    vr_lo  = cyc + 2;
                end
            end
            inv = inwin(cyc, vr_lo, vr_hi);
            for (int r = 0; r < ROWS; r++) v_data[r*DW +: DW] = fixed ? 32'h41200000 : $urandom;
            if (inv) begin
                if (gap > 0) begin
                    v_valid = 1'b0;
                    gap--;
                end else begin
                    v_valid = 1'b1;
                end
                v_last = (nv == nvec - 1);
            end else begin
                v_valid = 1'(($urandom_range(0, 1)));
                v_last  = 1'(($urandom_range(0, 1)));
            end
            if (inv && v_valid) begin
                v_evt[cyc] = v_data;
                nv++;
                case (vmode)
                    1:       gap = (nv == 1) ? 2 : 0;
                    2:       gap = $urandom_range(0, 3);
                    default: gap = 0;
                endcase
                if (v_last) begin
                    vr_hi    = cyc;
                    done_cyc = cyc + ROWS + 1;
                    busy_hi  = cyc + ROWS + 1;
                end
                if (stop_at > 0 && nv >= stop_at) stop = 1'b1;
            end
        end
        drive_quiet();
    endtask

    task automatic test_reset();
        clear_model();
        drive_quiet();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        idle(3);
    endtask

    task automatic test_weight_load_and_single_vector();
        run_job(1, 0, 0, 1'b1, 0);
        idle(4);
    endtask

    task automatic test_vector_gap();
        run_job(3, 0, 1, 1'b0, 0);
        idle(3);
    endtask

    task automatic test_toggled_weights();
        run_job(2, 1, 0, 1'b0, 0);
        idle(2);
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 4; j++) begin
            run_job($urandom_range(1, 6), 2, 2, 1'b0, 0);
            idle($urandom_range(0, 3));
        end
    endtask

    task automatic test_back_to_back();
        run_job(5, 0, 0, 1'b0, 0);
        run_job(5, 2, 2, 1'b0, 0);
        run_job(2, 0, 0, 1'b0, 0);
        idle(3);
    endtask

    task automatic test_reset_midjob();
        run_job(6, 0, 0, 1'b0, 2);
        reset = 1'b1;
        #1;
        checks++;
        if (pe_a_valid !== '0) begin errors++; $display("FAIL rst_pe_a_valid got=%b exp=0", pe_a_valid); end
        checks++;
        if (pe_a !== '0) begin errors++; $display("FAIL rst_pe_a got=%h exp=0", pe_a); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++;
        if ({w_ready, v_ready, pe_b_valid, pe_switch, done} !== 5'b0) begin
            errors++; $display("FAIL rst_ctrl got=%b exp=00000", {w_ready, v_ready, pe_b_valid, pe_switch, done});
        end
        checks++;
        if (pe_b !== '0) begin errors++; $display("FAIL rst_pe_b got=%h exp=0", pe_b); end
        clear_model();
        drive_quiet();
        step();
        step();
        reset = 1'b0;
        idle(8);
        run_job(2, 0, 2, 1'b0, 0);
        idle(2);
    endtask

    initial begin
        reset = 1'b1;
        drive_quiet();
        test_reset();
        test_weight_load_and_single_vector();
        test_vector_gap();
        test_toggled_weights();
        test_random_jobs();
        test_back_to_back();
        test_reset_midjob();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
